// File: rtl/scan_pkg.sv
// Shared definitions for the scan parameter loader: FSM state encoding,
// default timing constants and small elaboration-time helpers.
package scan_pkg;

    // Default parameter word width and serial timing (in timeclk cycles).
    localparam int SCAN_DATA_W     = 16;
    localparam int DEF_SETUP_CYC   = 2;
    localparam int DEF_STROBE_CYC  = 1;
    localparam int DEF_HOLD_CYC    = 2;

    // Load-and-scan sequence states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_START  = 3'd4,
        S_WAIT   = 3'd5,
        S_DONE   = 3'd6
    } scan_state_t;

    // Index width for a buffer of n words; never narrower than one bit.
    function automatic int scan_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Largest of the three phase lengths, used to size the phase counter.
    function automatic int scan_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/scan_param_buf.sv
// Parameter word buffer: one write port from the DSP side and a
// combinational read port indexed by the word currently being scanned.
module scan_param_buf #(
    parameter int NUM_PARAM = 2,
    parameter int DATA_W    = 16,
    parameter int SEL_W     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [SEL_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [NUM_PARAM];

    // Clear on reset; otherwise accept a qualified write (range and FSM
    // state are checked by the caller).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PARAM; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/scan_param_loader.sv
// Host-side transmitter for the scan state machine's parameter-load
// interface. Buffers DSP-written parameter words, presents each one as
// datain/scanchoice around a scanload strobe, pulses scanstart, then waits
// for a rising edge on intertodsp and raises done_irq for one cycle.
//
// Optional feature: define SCAN_TIMEOUT_EN to add parameter TIMEOUT_CYC and
// output timeout; a WAIT phase lasting TIMEOUT_CYC cycles without an edge
// then ends with timeout and done_irq pulsed together.
//
// Phase lengths SETUP_CYC, STROBE_CYC and HOLD_CYC are assumed to be >= 1.
module scan_param_loader
    import scan_pkg::*;
#(
    parameter int NUM_PARAM  = 2,
    parameter int DATA_W     = SCAN_DATA_W,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
`ifdef SCAN_TIMEOUT_EN
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int TIMEOUT_CYC = 65535
`else
    parameter int HOLD_CYC   = DEF_HOLD_CYC
`endif
) (
    input  logic                               timeclk,
    input  logic                               scanrst,
    input  logic                               wr_en,
    input  logic [scan_sel_w(NUM_PARAM)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic                               go,
    input  logic                               intertodsp,
    output logic [DATA_W-1:0]                  datain,
    output logic [scan_sel_w(NUM_PARAM)-1:0]   scanchoice,
    output logic                               scanload,
    output logic                               scanstart,
    output logic                               busy,
`ifdef SCAN_TIMEOUT_EN
    output logic                               timeout,
`endif
    output logic                               done_irq
);

    localparam int SEL_W   = scan_sel_w(NUM_PARAM);
    localparam int CNT_MAX = scan_max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [SEL_W-1:0] IDX_LAST    = SEL_W'(NUM_PARAM - 1);
    // One bit wider than the address so the range check is meaningful
    // even when NUM_PARAM is a power of two.
    localparam logic [SEL_W:0]   NUM_EXT     = (SEL_W + 1)'(NUM_PARAM);

    scan_state_t       state, nxt_state;
    logic [CNT_W-1:0]  cnt, nxt_cnt;
    logic [SEL_W-1:0]  idx, nxt_idx;
    logic              itd_prev;
    logic              itd_rise;
    logic              buf_we;
    logic [DATA_W-1:0] rd_data;

`ifdef SCAN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] wait_cnt;
    logic            to_flag, nxt_to;
`endif

    // Writes land only while idle and in range; a write coinciding with go
    // is committed on the same edge, so the sequence sees the new word.
    assign buf_we = wr_en && (state == S_IDLE) && ({1'b0, wr_addr} < NUM_EXT);

    // Done is a rising edge only: a level already high on entry to WAIT
    // was high in the previous cycle too and does not qualify.
    assign itd_rise = intertodsp && !itd_prev;

    scan_param_buf #(
        .NUM_PARAM (NUM_PARAM),
        .DATA_W    (DATA_W),
        .SEL_W     (SEL_W)
    ) u_buf (
        .clk     (timeclk),
        .rst     (scanrst),
        .wr_en   (buf_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

    // State, phase counter, word index and intertodsp history registers.
    always_ff @(posedge timeclk) begin
        if (scanrst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            itd_prev <= 1'b0;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            idx      <= nxt_idx;
            itd_prev <= intertodsp;
        end
    end

`ifdef SCAN_TIMEOUT_EN
    // WAIT-phase cycle count and the flag marking a timed-out completion.
    always_ff @(posedge timeclk) begin
        if (scanrst) begin
            wait_cnt <= '0;
            to_flag  <= 1'b0;
        end else begin
            wait_cnt <= (state == S_WAIT) ? wait_cnt + TO_W'(1) : '0;
            to_flag  <= nxt_to;
        end
    end
`endif

    // Next-state sequencing and Moore outputs.
    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        nxt_idx    = idx;
        datain     = '0;
        scanchoice = '0;
        scanload   = 1'b0;
        scanstart  = 1'b0;
        busy       = 1'b0;
        done_irq   = 1'b0;
`ifdef SCAN_TIMEOUT_EN
        nxt_to     = 1'b0;
        timeout    = to_flag;
`endif
        case (state)
            S_IDLE: begin
                if (go) begin
                    nxt_state = S_SETUP;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                end
            end
            S_SETUP: begin
                busy       = 1'b1;
                datain     = rd_data;
                scanchoice = idx;
                if (cnt == SETUP_LAST) begin
                    nxt_state = S_STROBE;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            S_STROBE: begin
                busy       = 1'b1;
                datain     = rd_data;
                scanchoice = idx;
                scanload   = 1'b1;
                if (cnt == STROBE_LAST) begin
                    nxt_state = S_HOLD;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                busy       = 1'b1;
                datain     = rd_data;
                scanchoice = idx;
                if (cnt == HOLD_LAST) begin
                    nxt_cnt = '0;
                    if (idx == IDX_LAST) begin
                        nxt_state = S_START;
                    end else begin
                        nxt_state = S_SETUP;
                        nxt_idx   = idx + SEL_W'(1);
                    end
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            S_START: begin
                busy      = 1'b1;
                scanstart = 1'b1;
                nxt_state = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (itd_rise) begin
                    nxt_state = S_DONE;
`ifdef SCAN_TIMEOUT_EN
                end else if (wait_cnt == TO_LAST) begin
                    nxt_state = S_DONE;
                    nxt_to    = 1'b1;
`endif
                end
            end
            S_DONE: begin
                done_irq  = 1'b1;
                nxt_state = S_IDLE;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/scan_param_loader.md
Name: scan_param_loader

Overview:
- Host-side transmitter for the scan state machine's parameter-load interface.
- Buffers the parameter words written by the DSP bus, then serially presents each word as datain/scanchoice with a scanload strobe.
- After the last word, issues a scanstart pulse, waits for the scan-done indication (intertodsp rising edge) and reports completion to the DSP.
- Sits between the DSP bus decoder and scanstatetop in the FPGA top level.

Parameters:
- NUM_PARAM, 2, number of parameter words per load sequence (index width SEL_W = clog2(NUM_PARAM), minimum 1).
- DATA_W, 16, parameter word width.
- SETUP_CYC, 2, cycles datain/scanchoice are stable before scanload rises.
- STROBE_CYC, 1, scanload high width in cycles (≥1).
- HOLD_CYC, 2, cycles datain/scanchoice are held after scanload falls.

Ports:
- timeclk, in, 1, sole clock; all logic on rising edge.
- scanrst, in, 1, reset; synchronous, active-high.
- wr_en, in, 1, DSP write strobe into parameter buffer.
- wr_addr, in, SEL_W, buffer index.
- wr_data, in, DATA_W, parameter word.
- go, in, 1, single-cycle request to start a load-and-scan sequence.
- intertodsp, in, 1, scan-done level from scan state machine.
- datain, out, DATA_W, word presented to scan state machine.
- scanchoice, out, SEL_W, index of presented word.
- scanload, out, 1, load strobe.
- scanstart, out, 1, one-cycle scan start pulse.
- busy, out, 1, sequence in progress.
- done_irq, out, 1, one-cycle completion pulse to DSP.

Behaviour:
- Reset: all outputs 0; buffer cleared to 0; FSM to IDLE; cycle counter and index to 0; intertodsp edge register to 0.
- Buffer writes: wr_en with wr_addr < NUM_PARAM writes in IDLE only. Writes while busy=1 are dropped. Writes with wr_addr ≥ NUM_PARAM are ignored.
- FSM states:
  - IDLE: busy=0. go=1 → SETUP, idx=0, busy=1 next cycle. A wr_en and go in the same cycle: the write lands first; the sequence uses the new word.
  - SETUP: datain=buf[idx], scanchoice=idx. Remain SETUP_CYC cycles → STROBE.
  - STROBE: scanload=1 for STROBE_CYC cycles, datain/scanchoice unchanged → HOLD.
  - HOLD: scanload=0, data held for HOLD_CYC cycles. If idx=NUM_PARAM-1 → START; else idx+1 → SETUP.
  - START: scanstart=1 for exactly one cycle → WAIT.
  - WAIT: detect intertodsp rising edge (registered previous value). A level already high on entry is not done. Edge → DONE.
  - DONE: done_irq=1 for one cycle, busy drops → IDLE.
- go is ignored outside IDLE.
- Per-word latency go→first scanload rise = 1+SETUP_CYC cycles. Total frame = NUM_PARAM×(SETUP_CYC+STROBE_CYC+HOLD_CYC) + 1 start cycle, excluding WAIT.
- scanrst mid-sequence: outputs go to 0 on the next edge, no further strobes, buffer cleared.
- datain/scanchoice are 0 in IDLE, START, WAIT and DONE.
- Counters are sized to clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC)+1) and never wrap.

Optional Feature:
- Macro SCAN_TIMEOUT_EN.
- Defined: parameter TIMEOUT_CYC (default 65535) and output timeout (1 bit, reset 0). If WAIT lasts TIMEOUT_CYC cycles without an edge, pulse timeout and done_irq together for one cycle → IDLE. An edge in the same cycle as expiry counts as normal done; timeout=0.
- Undefined: WAIT waits indefinitely; no timeout port.

Decomposition:
- Shared package scan_pkg:
  - FSM state encoding (IDLE, SETUP, STROBE, HOLD, START, WAIT, DONE).
  - Default timing constants SETUP_CYC/STROBE_CYC/HOLD_CYC.
  - DATA_W = 16.
- One sub-module, scan_param_buf: register array with write port and combinational read by idx.

Test Plan:
- Reset, then write buf[0]=16'h1234 and buf[1]=16'hABCD; pulse go:
  - datain=1234/scanchoice=0, scanload high cycles 4 after go (defaults).
  - Then ABCD/1, scanload high cycle 9.
  - scanstart pulses at cycle 12; busy=1 throughout.
- Drive intertodsp 0→1 twenty cycles after scanstart → done_irq one cycle later, busy=0; second go repeats identical waveform.
- During busy, write wr_addr=0 data 16'hFFFF and pulse go → buffer unchanged (next sequence still sends 1234), no restart.
- intertodsp held high before go → no completion on entry to WAIT; completion only after it falls and rises again.
- Assert scanrst during second STROBE → next cycle scanload=0, busy=0, datain=0; subsequent sequence sends 0000 for both words.
- With SCAN_TIMEOUT_EN and TIMEOUT_CYC=100, never raise intertodsp → timeout and done_irq pulse exactly 100 cycles after entering WAIT.
